// File: rtl/spi_pkg.sv
// Shared command encodings, FSM state type and counter width for the SPI initiator.
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_OUT,
        TURN,
        SHIFT_IN,
        HOLD
    } state_t;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host handshake plus SPI pin bundle; master modport is the controller's view.
interface spi_master_ctrl_if;

    logic       start;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       SS_n;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, cmd, wdata, MISO,
        output busy, done, rdata, rdata_valid, SS_n, SCLK, MOSI
    );

    modport slave (
        output start, cmd, wdata, MISO,
        input  busy, done, rdata, rdata_valid, SS_n, SCLK, MOSI
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles SCLK every CLK_DIV enabled cycles, idle low when disabled.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] phase;
    logic          tc;

    // Strobes flag the cycle whose closing edge moves SCLK.
    assign tc       = en && (phase == PW'(CLK_DIV - 1));
    assign rise_stb = tc && !sclk;
    assign fall_stb = tc && sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            sclk  <= 1'b0;
        end else if (!en) begin
            phase <= '0;
            sclk  <= 1'b0;
        end else if (tc) begin
            phase <= '0;
            sclk  <= ~sclk;
        end else begin
            phase <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator: sends {cmd,wdata} frames and, for read-data, collects a byte from MISO.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned TURN_BITS  = 2,
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_master_ctrl_if.master  bus
);

    state_t                  state, state_nxt;
    logic [FRAME_BITS-1:0]   tx_shift;
    logic [7:0]              rx_shift;
    logic [7:0]              rdata_q;
    logic [1:0]              cmd_q;
    logic [CNT_W-1:0]        cnt;
    logic                    sclk_en, sclk, rise_stb, fall_stb;
    logic                    ss_n, mosi, done, rdata_valid;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (sclk_en),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_comb begin
        state_nxt   = state;
        sclk_en     = 1'b0;
        ss_n        = 1'b1;
        mosi        = 1'b0;
        done        = 1'b0;
        rdata_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) state_nxt = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                sclk_en = 1'b1;
                ss_n    = 1'b0;
                mosi    = tx_shift[FRAME_BITS-1];
                if (fall_stb && cnt == CNT_W'(FRAME_BITS - 1))
                    state_nxt = (cmd_q == CMD_RD_DATA) ? TURN : HOLD;
            end
            TURN: begin
                sclk_en = 1'b1;
                ss_n    = 1'b0;
                if (fall_stb && cnt == CNT_W'(TURN_BITS - 1)) state_nxt = SHIFT_IN;
            end
            SHIFT_IN: begin
                sclk_en = 1'b1;
                ss_n    = 1'b0;
                if (fall_stb && cnt == CNT_W'(DATA_BITS - 1)) state_nxt = HOLD;
            end
            HOLD: begin
                if (cnt == CNT_W'(2 * CLK_DIV - 1)) begin
                    done        = 1'b1;
                    rdata_valid = (cmd_q == CMD_RD_DATA);
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // cnt counts SCLK periods in the shifting states and plain cycles in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            rdata_q  <= '0;
            cmd_q    <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (state != state_nxt)
                cnt <= '0;
            else if (state == HOLD || fall_stb)
                cnt <= cnt + 1'b1;

            if (state == IDLE && bus.start) begin
                tx_shift <= FRAME_BITS'({bus.cmd, bus.wdata});
                cmd_q    <= bus.cmd;
            end else if (state == SHIFT_OUT && fall_stb) begin
                tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
            end

            if (state == SHIFT_IN && rise_stb)
                rx_shift <= {rx_shift[6:0], bus.MISO};

            if (rdata_valid)
                rdata_q <= rx_shift;
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid;
    assign bus.SS_n        = ss_n;
    assign bus.SCLK        = sclk;
    assign bus.MOSI        = mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: two instances (CLK_DIV=2/TURN=2 and CLK_DIV=1/TURN=1).
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_ctrl_if b0 ();
    spi_master_ctrl_if b1 ();

    spi_master_ctrl #(.CLK_DIV(2), .TURN_BITS(2), .FRAME_BITS(10), .DATA_BITS(8)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (b0)
    );
    spi_master_ctrl #(.CLK_DIV(1), .TURN_BITS(1), .FRAME_BITS(10), .DATA_BITS(8)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (b1)
    );

    int tests = 0;
    int fails = 0;

    logic [1:0] sclk_v, ss_v, mosi_v, done_v, rv_v, busy_v;
    assign sclk_v = {b1.SCLK, b0.SCLK};
    assign ss_v   = {b1.SS_n, b0.SS_n};
    assign mosi_v = {b1.MOSI, b0.MOSI};
    assign done_v = {b1.done, b0.done};
    assign rv_v   = {b1.rdata_valid, b0.rdata_valid};
    assign busy_v = {b1.busy, b0.busy};

    int         rises [2];
    int         ss_low [2];
    int         dones [2];
    int         rvs [2];
    int         busys [2];
    int         frame_rise [2];
    int         turn_cfg [2] = '{2, 1};
    logic       prev_sclk [2] = '{1'b0, 1'b0};
    logic [9:0] mosi_word [2];
    logic [7:0] slave_byte [2];
    logic       miso_v [2] = '{1'bx, 1'bx};

    assign b0.MISO = miso_v[0];
    assign b1.MISO = miso_v[1];

    // Edge monitor and mode-0 slave model: MISO changes after each SCLK fall, X when not in data phase.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sclk_v[i] && !prev_sclk[i]) begin
                rises[i]++;
                if (frame_rise[i] < 10) mosi_word[i] = {mosi_word[i][8:0], mosi_v[i]};
                frame_rise[i]++;
            end
            if (!sclk_v[i] && prev_sclk[i]) begin
                int idx;
                idx = frame_rise[i] - (10 + turn_cfg[i]);
                miso_v[i] = (idx >= 0 && idx < 8) ? slave_byte[i][7 - idx] : 1'bx;
            end
            if (ss_v[i]) frame_rise[i] = 0;
            else         ss_low[i]++;
            if (done_v[i]) dones[i]++;
            if (rv_v[i])   rvs[i]++;
            if (busy_v[i]) busys[i]++;
            prev_sclk[i] = sclk_v[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic s, input logic [1:0] c, input logic [7:0] w);
        if (d == 0) begin b0.start = s; b0.cmd = c; b0.wdata = w; end
        else        begin b1.start = s; b1.cmd = c; b1.wdata = w; end
    endtask

    task automatic start_txn(input int d, input logic [1:0] c, input logic [7:0] w);
        @(negedge clk);
        drive(d, 1'b1, c, w);
        @(posedge clk);
        #1 drive(d, 1'b0, c, w);
    endtask

    task automatic wait_done(input int d, output int n);
        n = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (done_v[d]) begin
                n = k;
                break;
            end
        end
    endtask

    int lat;
    int r0, s0, d0, v0, bz0;

    initial begin
        drive(0, 1'b0, 2'b00, 8'h00);
        drive(1, 1'b0, 2'b00, 8'h00);
        slave_byte[0] = 8'h3C;
        slave_byte[1] = 8'h81;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_ss_n",  32'(b0.SS_n),        32'h1);
        chk("rst_sclk",  32'(b0.SCLK),        32'h0);
        chk("rst_mosi",  32'(b0.MOSI),        32'h0);
        chk("rst_busy",  32'(b0.busy),        32'h0);
        chk("rst_done",  32'(b0.done),        32'h0);
        chk("rst_rv",    32'(b0.rdata_valid), 32'h0);
        chk("rst_rdata", 32'(b0.rdata),       32'h00);
        rst_n = 1'b1;

        // Write-addr 0xA5
        r0 = rises[0]; s0 = ss_low[0]; d0 = dones[0]; v0 = rvs[0]; bz0 = busys[0];
        start_txn(0, 2'b00, 8'hA5);
        wait_done(0, lat); #1;
        chk("wa_latency", 32'(lat),              32'd44);
        chk("wa_mosi",    32'(mosi_word[0]),     32'h0A5);
        chk("wa_rises",   32'(rises[0] - r0),    32'd10);
        chk("wa_ss_low",  32'(ss_low[0] - s0),   32'd40);
        chk("wa_dones",   32'(dones[0] - d0),    32'd1);
        chk("wa_rv",      32'(rvs[0] - v0),      32'd0);
        chk("wa_busy",    32'(busys[0] - bz0),   32'd44);
        @(posedge clk); #1;
        chk("wa_idle_busy", 32'(b0.busy), 32'h0);

        // Read-data returning 0x3C
        r0 = rises[0]; d0 = dones[0]; v0 = rvs[0]; bz0 = busys[0];
        start_txn(0, 2'b11, 8'h00);
        wait_done(0, lat); #1;
        chk("rd_latency", 32'(lat),            32'd84);
        chk("rd_mosi",    32'(mosi_word[0]),   32'h300);
        chk("rd_rises",   32'(rises[0] - r0),  32'd20);
        chk("rd_dones",   32'(dones[0] - d0),  32'd1);
        chk("rd_rv",      32'(rvs[0] - v0),    32'd1);
        chk("rd_busy",    32'(busys[0] - bz0), 32'd84);
        @(posedge clk); #1;
        chk("rd_rdata",   32'(b0.rdata),       32'h3C);

        // Write-data 0x5A with a stray start mid-frame
        r0 = rises[0]; d0 = dones[0];
        start_txn(0, 2'b01, 8'h5A);
        repeat (10) @(negedge clk);
        drive(0, 1'b1, 2'b11, 8'hFF);
        @(negedge clk);
        drive(0, 1'b0, 2'b11, 8'hFF);
        wait_done(0, lat); #1;
        chk("ign_latency", 32'(lat),           32'd33);
        chk("ign_mosi",    32'(mosi_word[0]),  32'h15A);
        chk("ign_rises",   32'(rises[0] - r0), 32'd10);
        repeat (100) @(negedge clk); #1;
        chk("ign_dones",   32'(dones[0] - d0), 32'd1);
        chk("ign_busy",    32'(b0.busy),       32'h0);
        chk("ign_rdata_hold", 32'(b0.rdata),   32'h3C);

        // Reset at the 5th SCLK rise of a read-addr frame
        d0 = dones[0];
        start_txn(0, 2'b10, 8'hC3);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (frame_rise[0] == 5) break;
        end
        chk("abort_at_rise5", 32'(frame_rise[0]), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("abort_ss_n",  32'(b0.SS_n),  32'h1);
        chk("abort_sclk",  32'(b0.SCLK),  32'h0);
        chk("abort_busy",  32'(b0.busy),  32'h0);
        chk("abort_rdata", 32'(b0.rdata), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk); #1;
        chk("abort_no_done", 32'(dones[0] - d0), 32'd0);

        r0 = rises[0];
        start_txn(0, 2'b00, 8'h0F);
        wait_done(0, lat); #1;
        chk("post_latency", 32'(lat),           32'd44);
        chk("post_mosi",    32'(mosi_word[0]),  32'h00F);
        chk("post_rises",   32'(rises[0] - r0), 32'd10);

        // CLK_DIV=1: write-data 0xFF then read-data with start held
        @(negedge clk);
        drive(1, 1'b1, 2'b01, 8'hFF);
        @(posedge clk);
        #1 drive(1, 1'b1, 2'b11, 8'h00);
        wait_done(1, lat); #1;
        chk("b2b_wd_latency", 32'(lat),          32'd22);
        chk("b2b_wd_mosi",    32'(mosi_word[1]), 32'h1FF);
        r0 = rises[1]; d0 = dones[1]; v0 = rvs[1]; bz0 = busys[1];
        @(negedge clk); #1;
        chk("b2b_gap_busy",   32'(b1.busy),      32'h0);
        @(posedge clk);
        #1 drive(1, 1'b0, 2'b11, 8'h00);
        wait_done(1, lat); #1;
        chk("b2b_rd_latency", 32'(lat),            32'd40);
        chk("b2b_rd_mosi",    32'(mosi_word[1]),   32'h300);
        chk("b2b_rd_rises",   32'(rises[1] - r0),  32'd19);
        chk("b2b_rd_busy",    32'(busys[1] - bz0), 32'd40);
        chk("b2b_rd_dones",   32'(dones[1] - d0),  32'd1);
        chk("b2b_rd_rv",      32'(rvs[1] - v0),    32'd1);
        @(posedge clk); #1;
        chk("b2b_rd_rdata",   32'(b1.rdata),       32'h81);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
